fem_cfg_writer: RTL and testbench

- 3-wire serial configuration writer for the GNSS RF front-end (FEM) chip; drives the FEM's CS_n/SCLK/SDATA pins that the FPGA test top currently ties to constants.
- Sits upstream of the FEM and its sample-capture path. It accepts one register write, consisting of a 4-bit address and 28-bit data, through a valid/ready handshake. It serialises each write as a 32-bit MSB-first frame.

---
 rtl/fem_cfg_writer.sv | 127 ++++++++++++
 tb/tb_fem_cfg_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fem_cfg_writer.sv
// rtl/fem_cfg_writer.sv - 3-wire serial register writer for the GNSS RF front-end (FEM)

module fem_cfg_writer #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic [27:0] wr_data,
    output logic        done,
    output logic        fem_cs_n,
    output logic        fem_sclk,
    output logic        fem_sdata
);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("fem_cfg_writer: CLK_DIV must be in 1..255");
    end

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  div, div_nx;
    logic [4:0]  bit_cnt, bit_nx;
    logic        phase, phase_nx;
    logic [31:0] frame, frame_nx;
    logic        div_end;
    logic        ready_nx, done_nx, cs_n_nx, sclk_nx, sdata_nx;

    assign div_end = (div == DIV_LAST);

    always_comb begin
        state_nx = state;
        div_nx   = div;
        bit_nx   = bit_cnt;
        phase_nx = phase;
        frame_nx = frame;
        case (state)
            IDLE: begin
                if (wr_valid && wr_ready) begin
                    state_nx = SHIFT;
                    frame_nx = {wr_data, wr_addr};
                    div_nx   = 8'd0;
                    bit_nx   = 5'd31;
                    phase_nx = 1'b0;
                end
            end
            SHIFT: begin
                // phase 0 = SCLK low half, phase 1 = SCLK high half of the current bit
                if (div_end) begin
                    div_nx = 8'd0;
                    if (!phase) begin
                        phase_nx = 1'b1;
                    end else if (bit_cnt == 5'd0) begin
                        state_nx = HOLD;
                        phase_nx = 1'b0;
                    end else begin
                        bit_nx   = bit_cnt - 5'd1;
                        phase_nx = 1'b0;
                    end
                end else begin
                    div_nx = div + 8'd1;
                end
            end
            HOLD: begin
                if (div_end) begin
                    div_nx   = 8'd0;
                    state_nx = GAP;
                end else begin
                    div_nx = div + 8'd1;
                end
            end
            GAP: begin
                if (div_end) begin
                    div_nx   = 8'd0;
                    state_nx = IDLE;
                end else begin
                    div_nx = div + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Pins are decoded from the next state so every output leaves a flop.
        ready_nx = (state_nx == IDLE);
        cs_n_nx  = !(state_nx == SHIFT || state_nx == HOLD);
        sclk_nx  = (state_nx == SHIFT) && phase_nx;
        sdata_nx = !cs_n_nx && frame_nx[bit_nx];
        done_nx  = (state_nx == GAP) && (div_nx == DIV_LAST);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            div       <= 8'd0;
            bit_cnt   <= 5'd0;
            phase     <= 1'b0;
            frame     <= 32'd0;
            wr_ready  <= 1'b1;
            done      <= 1'b0;
            fem_cs_n  <= 1'b1;
            fem_sclk  <= 1'b0;
            fem_sdata <= 1'b0;
        end else begin
            state     <= state_nx;
            div       <= div_nx;
            bit_cnt   <= bit_nx;
            phase     <= phase_nx;
            frame     <= frame_nx;
            wr_ready  <= ready_nx;
            done      <= done_nx;
            fem_cs_n  <= cs_n_nx;
            fem_sclk  <= sclk_nx;
            fem_sdata <= sdata_nx;
        end
    end

endmodule

// File: tb/tb_fem_cfg_writer.sv
// tb/tb_fem_cfg_writer.sv - directed bench for fem_cfg_writer at CLK_DIV=4 and CLK_DIV=1
`timescale 1ns/1ps

module tb_fem_cfg_writer;

    logic        clk = 1'b0;
    logic        nrst;
    logic [1:0]  m_valid, m_ready, m_done, m_cs_n, m_sclk, m_sdata;
    logic [3:0]  addr_a, addr_b;
    logic [27:0] data_a, data_b;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    logic [31:0] word[2];
    int rises[2], cs_low[2], ready_low[2], dones[2], viol[2], cs_falls[2];
    int pmin[2], pmax[2], last_rise[2], done_cyc[2], csfall_cyc[2], csrise_cyc[2];
    logic p_sclk[2], p_cs[2];

    fem_cfg_writer #(.CLK_DIV(4)) dut_a (
        .clk(clk), .nrst(nrst), .wr_valid(m_valid[0]), .wr_ready(m_ready[0]),
        .wr_addr(addr_a), .wr_data(data_a), .done(m_done[0]),
        .fem_cs_n(m_cs_n[0]), .fem_sclk(m_sclk[0]), .fem_sdata(m_sdata[0])
    );

    fem_cfg_writer #(.CLK_DIV(1)) dut_b (
        .clk(clk), .nrst(nrst), .wr_valid(m_valid[1]), .wr_ready(m_ready[1]),
        .wr_addr(addr_b), .wr_data(data_b), .done(m_done[1]),
        .fem_cs_n(m_cs_n[1]), .fem_sclk(m_sclk[1]), .fem_sdata(m_sdata[1])
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pin observer: decodes the serial word and tallies timing/invariants per DUT.
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (m_sclk[k] && !p_sclk[k]) begin
                word[k] = {word[k][30:0], m_sdata[k]};
                if (rises[k] > 0) begin
                    if (cyc - last_rise[k] < pmin[k]) pmin[k] = cyc - last_rise[k];
                    if (cyc - last_rise[k] > pmax[k]) pmax[k] = cyc - last_rise[k];
                end
                last_rise[k] = cyc;
                rises[k]++;
            end
            if (!m_cs_n[k]) cs_low[k]++;
            if (!m_ready[k]) ready_low[k]++;
            if (m_done[k]) begin
                dones[k]++;
                done_cyc[k] = cyc;
            end
            if (m_done[k] && m_ready[k]) viol[k]++;
            if (m_sclk[k] && m_cs_n[k]) viol[k]++;
            if (m_sdata[k] && m_cs_n[k]) viol[k]++;
            if ((m_cs_n[k] !== p_cs[k]) && m_sclk[k]) viol[k]++;
            if (m_cs_n[k] && !p_cs[k]) csrise_cyc[k] = cyc;
            if (!m_cs_n[k] && p_cs[k]) begin
                csfall_cyc[k] = cyc;
                cs_falls[k]++;
            end
            p_sclk[k] = m_sclk[k];
            p_cs[k]   = m_cs_n[k];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon(input int k);
        word[k]      = 32'd0;
        rises[k]     = 0;
        cs_low[k]    = 0;
        ready_low[k] = 0;
        dones[k]     = 0;
        viol[k]      = 0;
        cs_falls[k]  = 0;
        pmin[k]      = 1000000;
        pmax[k]      = 0;
    endtask

    task automatic wait_done(input int k, input int budget, input string tag);
        int start = dones[k];
        int n = 0;
        while (dones[k] == start && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(dones[k] != start), 32'd1);
    endtask

    task automatic start_write(input int k, input logic [3:0] a, input logic [27:0] d);
        if (k == 0) begin
            addr_a = a; data_a = d;
        end else begin
            addr_b = a; data_b = d;
        end
        m_valid[k] = 1'b1;
        tick();
        m_valid[k] = 1'b0;
        check($sformatf("accept_ready_low_%0d", k), 32'(m_ready[k]), 32'd0);
    endtask

    logic [31:0] w1;
    int d1, r1, n;

    initial begin
        for (int k = 0; k < 2; k++) begin
            p_sclk[k] = 1'b0;
            p_cs[k]   = 1'b1;
            clear_mon(k);
        end
        nrst    = 1'b0;
        m_valid = 2'b00;
        addr_a  = 4'h0; data_a = 28'h0;
        addr_b  = 4'h0; data_b = 28'h0;
        tick();
        tick();
        nrst = 1'b1;
        tick();

        // Reset state and 20 idle cycles
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_ready_%0d", k), 32'(m_ready[k]), 32'd1);
            check($sformatf("rst_cs_n_%0d", k), 32'(m_cs_n[k]), 32'd1);
            check($sformatf("rst_sclk_%0d", k), 32'(m_sclk[k]), 32'd0);
            check($sformatf("rst_sdata_%0d", k), 32'(m_sdata[k]), 32'd0);
            check($sformatf("rst_done_%0d", k), 32'(m_done[k]), 32'd0);
            clear_mon(k);
        end
        repeat (20) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("idle_cs_low_%0d", k), cs_low[k], 0);
            check($sformatf("idle_rises_%0d", k), rises[k], 0);
            check($sformatf("idle_dones_%0d", k), dones[k], 0);
            check($sformatf("idle_ready_low_%0d", k), ready_low[k], 0);
            check($sformatf("idle_viol_%0d", k), viol[k], 0);
        end

        // Single write at CLK_DIV=4
        clear_mon(0);
        start_write(0, 4'h3, 28'hEAFF1DC);
        wait_done(0, 400, "w1_done_seen");
        tick();
        check("w1_word", word[0], 32'hEAFF1DC3);
        check("w1_rises", rises[0], 32);
        check("w1_cs_low", cs_low[0], 260);
        check("w1_period_min", pmin[0], 8);
        check("w1_period_max", pmax[0], 8);
        check("w1_dones", dones[0], 1);
        check("w1_ready_low", ready_low[0], 264);
        check("w1_ready_back", 32'(m_ready[0]), 32'd1);
        check("w1_viol", viol[0], 0);

        // Back-to-back writes with wr_valid held high
        clear_mon(0);
        addr_a = 4'h0; data_a = 28'hA2919A3;
        m_valid[0] = 1'b1;
        wait_done(0, 700, "b2b_done1_seen");
        w1 = word[0];
        d1 = done_cyc[0];
        r1 = csrise_cyc[0];
        addr_a = 4'h1; data_a = 28'h8550308;
        word[0] = 32'd0;
        rises[0] = 0;
        tick();
        tick();
        check("b2b_cs2_low", 32'(m_cs_n[0]), 32'd0);
        m_valid[0] = 1'b0;
        check("b2b_word1", w1, 32'hA2919A30);
        check("b2b_accept_after_done", csfall_cyc[0] - d1, 2);
        check("b2b_gap_ge_div", 32'(csfall_cyc[0] - r1 >= 4), 32'd1);
        wait_done(0, 700, "b2b_done2_seen");
        check("b2b_word2", word[0], 32'h85503081);
        check("b2b_rises2", rises[0], 32);
        check("b2b_frames", cs_falls[0], 2);
        check("b2b_viol", viol[0], 0);

        // wr_* changed mid-frame while wr_valid=0
        tick();
        clear_mon(0);
        start_write(0, 4'h5, 28'h1234567);
        repeat (50) tick();
        addr_a = 4'hA; data_a = 28'hFEDCBA9;
        wait_done(0, 400, "hold_done_seen");
        check("hold_word", word[0], 32'h12345675);
        repeat (10) tick();
        check("hold_frames", cs_falls[0], 1);
        check("hold_dones", dones[0], 1);
        check("hold_ready", 32'(m_ready[0]), 32'd1);

        // Reset during bit 15
        clear_mon(0);
        start_write(0, 4'h3, 28'hEAFF1DC);
        n = 0;
        while (rises[0] < 17 && n < 400) begin
            tick();
            n++;
        end
        check("abort_reached_bit15", rises[0], 17);
        nrst = 1'b0;
        #1;
        check("abort_cs_n", 32'(m_cs_n[0]), 32'd1);
        check("abort_sclk", 32'(m_sclk[0]), 32'd0);
        check("abort_sdata", 32'(m_sdata[0]), 32'd0);
        check("abort_ready", 32'(m_ready[0]), 32'd1);
        tick();
        nrst = 1'b1;
        repeat (5) tick();
        check("abort_no_done", dones[0], 0);
        clear_mon(0);
        start_write(0, 4'h2, 28'h0EAFF1D);
        wait_done(0, 400, "abort_new_done_seen");
        check("abort_new_word", word[0], 32'h0EAFF1D2);
        check("abort_new_rises", rises[0], 32);
        check("abort_new_viol", viol[0], 0);

        // CLK_DIV=1 instance
        clear_mon(1);
        start_write(1, 4'hF, 28'hFFFFFFF);
        wait_done(1, 200, "div1_done_seen");
        tick();
        check("div1_word", word[1], 32'hFFFFFFFF);
        check("div1_rises", rises[1], 32);
        check("div1_period_min", pmin[1], 2);
        check("div1_period_max", pmax[1], 2);
        check("div1_cs_low", cs_low[1], 65);
        check("div1_ready_low", ready_low[1], 66);
        check("div1_dones", dones[1], 1);
        check("div1_viol", viol[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
